// File: rtl/sync_down_counter_if.sv
// Bus bundle for sync_down_counter: load/enable controls in, count and status out.
// The master side (controller / testbench) drives load, load_val and en; the
// slave side (the counter) returns the registered count Q, tc and busy.
interface sync_down_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (
    output load,
    output load_val,
    output en,
    input  Q,
    input  tc,
    input  busy
  );

  modport slave (
    input  load,
    input  load_val,
    input  en,
    output Q,
    output tc,
    output busy
  );

endinterface : sync_down_counter_if

// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter / countdown timer.
// - load captures load_val into Q and into the reload register; a non-zero
//   value starts a countdown (RUN), a zero value expires at once (tc pulse).
// - In RUN, each enabled cycle decrements Q; the step from 1 to 0 raises tc
//   for one cycle and returns to IDLE.
// - Priority at each edge: reset > load > en. All outputs are registered.
// Optional build macro: SYNC_DOWN_COUNTER_AUTORELOAD_EN
//   When defined, the 1 -> expiry step reloads Q from the reload register and
//   stays in RUN, giving a periodic tc every N enabled cycles for a load of N.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  sync_down_counter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // Next-state logic: load first, then enabled countdown in RUN; tc defaults low.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      q_d      = bus.load_val;
      reload_d = bus.load_val;
      if (bus.load_val != CNT_ZERO) begin
        state_d = RUN;
      end else begin
        // A zero load expires immediately.
        state_d = IDLE;
        tc_d    = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Q holds and en is ignored; no wrap below zero.
          state_d = IDLE;
        end
        RUN: begin
          if (bus.en) begin
            if (q_q > CNT_ONE) begin
              q_d = q_q - CNT_ONE;
            end else begin
              tc_d = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
              // Periodic mode: restart from the last loaded value.
              q_d     = reload_q;
              state_d = RUN;
`else
              // One-shot mode: land on zero and stop.
              q_d     = CNT_ZERO;
              state_d = IDLE;
`endif
            end
          end else begin
            // Paused: everything holds.
            state_d = RUN;
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe stopped state.
          state_d = IDLE;
          q_d     = CNT_ZERO;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule : sync_down_counter
